// File: rtl/accum_prod_to_posit_es3_pkg.sv
// Shared types and helpers for converting es3 accumulator values to posits.
package accum_prod_to_posit_es3_pkg;

  localparam int FBITS_ACCUM = 32;
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3 = 1 + 10 + FBITS_ACCUM + 2;
  localparam int POSIT_NBITS_ES3 = 32;
  localparam int MAXSCALE_ES3 = 8 * (POSIT_NBITS_ES3 - 2);

  // Serialized accumulator value as produced by the product accumulator.
  typedef struct packed {
    logic                    sgn;
    logic signed [9:0]       scale;
    logic [FBITS_ACCUM-1:0]  fraction;
    logic                    inf;
    logic                    zero;
  } value_accum_prod;

  typedef struct packed {
    logic                       sgn;
    logic [POSIT_NBITS_ES3-2:0] body;
  } posit_enc_es3_t;

  // Largest scale representable by an n-bit es3 posit.
  function automatic int posit_maxscale(input int n);
    return 8 * (n - 2);
  endfunction

  // Positive posit word with every body bit set.
  function automatic logic [31:0] posit_maxpos(input int n);
    return (32'h1 << (n - 1)) - 32'h1;
  endfunction

  // Smallest positive posit word.
  function automatic logic [31:0] posit_minpos(input int n);
    return (n > 0) ? 32'h1 : 32'h0;
  endfunction

endpackage

// File: rtl/posit_round_rne_es3.sv
// Builds the regime/exponent/fraction string of an es3 posit body and rounds it
// to NBITS-1 bits with round-to-nearest-even. Purely combinational.
module posit_round_rne_es3
  import accum_prod_to_posit_es3_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int FBITS = 32
) (
  input  logic signed [6:0]  i_k,
  input  logic [2:0]         i_e,
  input  logic [FBITS-1:0]   i_frac,
  input  logic               i_clamp_hi,
  input  logic               i_clamp_lo,
  output logic [NBITS-2:0]   o_body,
  output logic               o_inexact
);

  localparam int YW = FBITS + 4;
  localparam int W  = YW + NBITS;
  localparam logic [31:0] MAXPOS = posit_maxpos(NBITS);
  localparam logic [31:0] MINPOS = posit_minpos(NBITS);

  logic              w_kpos;
  logic signed [7:0] w_kx;
  logic [7:0]        w_shamt;
  logic [W-1:0]      w_y, w_fill, w_x;
  logic [NBITS-2:0]  w_trunc;
  logic              w_guard, w_sticky, w_up;
  logic [NBITS-1:0]  w_sum;

  // k >= 0: (k+1) ones then 0; k < 0: (-k) zeros then 1. The terminating
  // regime bit sits at the top of w_y, the run comes from the shift fill.
  assign w_kpos  = ~i_k[6];
  assign w_kx    = i_k;
  assign w_shamt = w_kpos ? w_kx + 8'sd1 : -w_kx;
  assign w_y     = {~w_kpos, i_e, i_frac, {NBITS{1'b0}}};
  assign w_fill  = w_kpos ? ~({W{1'b1}} >> w_shamt) : '0;
  assign w_x     = (w_y >> w_shamt) | w_fill;

  assign w_trunc  = w_x[W-1 -: NBITS-1];
  assign w_guard  = w_x[W-NBITS];
  assign w_sticky = |w_x[W-NBITS-1:0];
  assign w_up     = w_guard & (w_trunc[0] | w_sticky);
  assign w_sum    = {1'b0, w_trunc} + {{(NBITS-1){1'b0}}, w_up};

  // Rounded body, with carry-out and out-of-range scales pinned to maxpos/minpos.
  always_comb begin
    o_body    = w_sum[NBITS-2:0];
    o_inexact = w_guard | w_sticky;
    if (w_sum[NBITS-1]) o_body = MAXPOS[NBITS-2:0];
    if (i_clamp_hi) begin
      o_body    = MAXPOS[NBITS-2:0];
      o_inexact = 1'b1;
    end else if (i_clamp_lo) begin
      o_body    = MINPOS[NBITS-2:0];
      o_inexact = 1'b1;
    end
  end

endmodule

// File: rtl/accum_prod_to_posit_es3.sv
// Three-stage accumulator-value to es3 posit converter with a 2-entry skid
// buffer on the output: S1 decode/clamp, S2 regime build + RNE, S3 pack.
module accum_prod_to_posit_es3
  import accum_prod_to_posit_es3_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int ES    = 3
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1:0] in_data,
  input  logic                                             in_truncated,
  output logic                                             in_ready,
  output logic                                             out_valid,
  output logic [NBITS-1:0]                                 out_posit,
  output logic                                             out_inexact,
  input  logic                                             out_ready,
  output logic                                             overrun
);

  if (ES != 3) begin : g_bad_es
    $error("accum_prod_to_posit_es3 only supports ES=3");
  end
  if (NBITS < 16 || NBITS > 32) begin : g_bad_nbits
    $error("accum_prod_to_posit_es3 supports NBITS 16..32");
  end

  localparam int MAXSCALE = posit_maxscale(NBITS);
  localparam logic signed [9:0] LIM_HI = 10'(MAXSCALE);
  localparam logic signed [9:0] LIM_LO = 10'(-MAXSCALE);

  value_accum_prod   w_in;
  logic signed [9:0] w_scale;
  logic              w_in_vld, w_adv, w_push, w_pop;
  logic [1:0]        w_cnt_nxt;
  logic [NBITS-2:0]  w_body;
  logic              w_rnd_inx;
  logic [NBITS-1:0]  w_mag, w_pk_posit;
  logic              w_pk_inx;

  logic [1:0]              r_vld_pipe;
  logic                    r_s1_sgn, r_s1_inf, r_s1_zero, r_s1_trunc, r_s1_hi, r_s1_lo;
  logic signed [6:0]       r_s1_k;
  logic [2:0]              r_s1_e;
  logic [FBITS_ACCUM-1:0]  r_s1_frac;
  logic [NBITS-2:0]        r_s2_body;
  logic                    r_s2_sgn, r_s2_inf, r_s2_zero, r_s2_inx;
  logic [NBITS-1:0]        r_b0_posit, r_b1_posit;
  logic                    r_b0_inx, r_b1_inx;
  logic [1:0]              r_cnt;
  logic                    r_in_ready, r_overrun;

  assign w_in     = in_data;
  assign w_scale  = w_in.scale;
  assign w_in_vld = (in_valid === 1'b1);

  // Stages only move when the skid buffer can take whatever leaves S2.
  assign w_pop     = (r_cnt != 2'd0) & out_ready;
  assign w_adv     = (r_cnt != 2'd2) | w_pop;
  assign w_push    = w_adv & r_vld_pipe[1];
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  // Stage valid shift register; a stalled in_ready beat enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst)        r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[0], w_in_vld & r_in_ready};
  end

  // S1 and S2 datapath registers, enabled with the pipeline advance.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_sgn   <= w_in.sgn;
      r_s1_k     <= w_scale[9:3];
      r_s1_e     <= w_scale[2:0];
      r_s1_frac  <= w_in.fraction;
      r_s1_inf   <= w_in.inf;
      r_s1_zero  <= w_in.zero;
      r_s1_trunc <= in_truncated;
      r_s1_hi    <= (w_scale > LIM_HI);
      r_s1_lo    <= (w_scale < LIM_LO);
      r_s2_body  <= w_body;
      r_s2_inx   <= w_rnd_inx | r_s1_trunc;
      r_s2_sgn   <= r_s1_sgn;
      r_s2_inf   <= r_s1_inf;
      r_s2_zero  <= r_s1_zero;
    end
  end

  posit_round_rne_es3 #(.NBITS(NBITS), .FBITS(FBITS_ACCUM)) u_round (
    .i_k        (r_s1_k),
    .i_e        (r_s1_e),
    .i_frac     (r_s1_frac),
    .i_clamp_hi (r_s1_hi),
    .i_clamp_lo (r_s1_lo),
    .o_body     (w_body),
    .o_inexact  (w_rnd_inx)
  );

  // S3 pack: sign via two's complement of the whole word; NaR beats zero.
  assign w_mag = {1'b0, r_s2_body};
  always_comb begin
    w_pk_posit = r_s2_sgn ? -w_mag : w_mag;
    w_pk_inx   = r_s2_inx;
    if (r_s2_inf) begin
      w_pk_posit = {1'b1, {(NBITS-1){1'b0}}};
      w_pk_inx   = 1'b0;
    end else if (r_s2_zero) begin
      w_pk_posit = '0;
      w_pk_inx   = 1'b0;
    end
  end

  // Skid FIFO: entry 0 is the head; ready/overrun track its occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b1;
      r_overrun  <= 1'b0;
      r_b0_posit <= '0;
      r_b1_posit <= '0;
      r_b0_inx   <= 1'b0;
      r_b1_inx   <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= (w_cnt_nxt != 2'd2);
      if (w_in_vld & ~r_in_ready) r_overrun <= 1'b1;
      if (w_pop) begin
        if (r_cnt == 2'd2) begin
          r_b0_posit <= r_b1_posit;
          r_b0_inx   <= r_b1_inx;
          if (w_push) begin
            r_b1_posit <= w_pk_posit;
            r_b1_inx   <= w_pk_inx;
          end
        end else if (w_push) begin
          r_b0_posit <= w_pk_posit;
          r_b0_inx   <= w_pk_inx;
        end
      end else if (w_push) begin
        if (r_cnt == 2'd0) begin
          r_b0_posit <= w_pk_posit;
          r_b0_inx   <= w_pk_inx;
        end else begin
          r_b1_posit <= w_pk_posit;
          r_b1_inx   <= w_pk_inx;
        end
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_cnt != 2'd0);
  assign out_posit   = r_b0_posit;
  assign out_inexact = r_b0_inx;
  assign overrun     = r_overrun;

endmodule
